// File: rtl/jtag_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_host_pkg
// Description : Shared op codes, TMS header/trailer patterns and FSM state
//               encoding for the JTAG host-side sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_host_pkg;

    // Command op codes
    localparam logic [1:0] OP_RESET    = 2'd0;
    localparam logic [1:0] OP_IDLE     = 2'd1;
    localparam logic [1:0] OP_SHIFT_IR = 2'd2;
    localparam logic [1:0] OP_SHIFT_DR = 2'd3;

    // TMS patterns, LSB is the first tick
    localparam logic [3:0] C_IR_HDR_PAT = 4'b0011;
    localparam int         C_IR_HDR_LEN = 4;
    localparam logic [2:0] C_DR_HDR_PAT = 3'b001;
    localparam int         C_DR_HDR_LEN = 3;
    localparam logic [1:0] C_TRL_PAT    = 2'b01;
    localparam int         C_TRL_LEN    = 2;
    localparam logic [5:0] C_RST_PAT    = 6'b011111;
    localparam int         C_RST_LEN    = 6;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_SHIFT = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tck_gen
// Description : TCK generator. Counts CLK_DIV low cycles then CLK_DIV high
//               cycles while enabled and flags the cycle before each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int           PW        = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] C_RISE_AT = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] C_FALL_AT = PW'(2 * CLK_DIV - 1);

    logic [PW-1:0] r_phase;
    logic          r_tck;

    // Strobes mark the cycle whose closing edge moves TCK
    assign o_rise_stb = i_en && (r_phase == C_RISE_AT);
    assign o_fall_stb = i_en && (r_phase == C_FALL_AT);
    assign o_tck      = r_tck;

    // Phase counter; parked at zero so a new command starts a fresh low phase
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_phase <= '0;
        end else if (r_phase == C_FALL_AT) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PW'(1);
        end
    end

    // Registered TCK driven from the strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tck <= 1'b0;
        end else if (o_rise_stb) begin
            r_tck <= 1'b1;
        end else if (o_fall_stb) begin
            r_tck <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_host_shifter.sv
`default_nettype none
// ============================================================================
// Module      : jtag_host_shifter
// Description : JTAG host sequencer. Runs one RESET / IDLE / SHIFT_IR /
//               SHIFT_DR command at a time, drives TMS/TDI on TCK low phases
//               and captures TDO into a right-aligned response word.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_host_shifter
    import jtag_host_pkg::*;
#(
    parameter int  MAX_LEN = 32,
    parameter int  CLK_DIV = 2,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [LW-1:0]      CMD_LEN,
    input  logic [MAX_LEN-1:0] CMD_DATA,
    output logic               RSP_VALID,
    output logic [MAX_LEN-1:0] RSP_DATA,
    output logic               BUSY,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    // Counter must also hold the longest header length minus one
    localparam int            CW        = (LW > 3) ? LW : 3;
    localparam logic [LW-1:0] C_MAX_LEN = LW'(MAX_LEN);

    state_t             r_state;
    logic [1:0]         r_op;
    logic [CW-1:0]      r_len;
    logic [CW-1:0]      r_cnt;
    logic [5:0]         r_pat;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_mask;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic               r_rsp_valid;
    logic               r_tms;
    logic               r_tdi;

    logic               w_ready;
    logic               w_accept;
    logic               w_en;
    logic               w_rise;
    logic               w_fall;
    logic               w_scan;
    logic [LW-1:0]      w_len;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = CMD_VALID && w_ready;
    assign w_en     = (r_state == S_PRE) || (r_state == S_SHIFT) || (r_state == S_POST);
    assign w_scan   = (r_op != OP_IDLE);
    assign w_len    = (CMD_LEN > C_MAX_LEN) ? C_MAX_LEN : CMD_LEN;

    assign CMD_READY = w_ready;
    assign BUSY      = ~w_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_DATA  = r_rsp_data;
    assign TMS       = r_tms;
    assign TDI       = r_tdi;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk        (CLK),
        .rst        (RST),
        .i_en       (w_en),
        .o_tck      (TCK),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall)
    );

    // Command sequencer: TMS/TDI update on each TCK fall, TDO capture on rise
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_op        <= OP_RESET;
            r_len       <= '0;
            r_cnt       <= '0;
            r_pat       <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_cap       <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_op   <= CMD_OP;
                        r_len  <= CW'(w_len);
                        r_data <= CMD_DATA;
                        r_mask <= MAX_LEN'(1);
                        r_cap  <= '0;
                        r_tdi  <= 1'b0;
                        if (CMD_OP == OP_RESET) begin
                            r_state <= S_PRE;
                            r_pat   <= C_RST_PAT;
                            r_cnt   <= CW'(C_RST_LEN - 1);
                            r_tms   <= C_RST_PAT[0];
                        end else if (w_len == '0) begin
                            // Nothing to clock: complete immediately
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                            r_tms       <= 1'b0;
                        end else if (CMD_OP == OP_IDLE) begin
                            r_state <= S_SHIFT;
                            r_cnt   <= CW'(w_len) - CW'(1);
                            r_tms   <= 1'b0;
                        end else if (CMD_OP == OP_SHIFT_IR) begin
                            r_state <= S_PRE;
                            r_pat   <= {2'b00, C_IR_HDR_PAT};
                            r_cnt   <= CW'(C_IR_HDR_LEN - 1);
                            r_tms   <= C_IR_HDR_PAT[0];
                        end else begin
                            r_state <= S_PRE;
                            r_pat   <= {3'b000, C_DR_HDR_PAT};
                            r_cnt   <= CW'(C_DR_HDR_LEN - 1);
                            r_tms   <= C_DR_HDR_PAT[0];
                        end
                    end
                end
                S_PRE: begin
                    if (w_fall) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CW'(1);
                            r_pat <= {1'b0, r_pat[5:1]};
                            r_tms <= r_pat[1];
                        end else if (r_op == OP_RESET) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_cap;
                            r_tms       <= 1'b0;
                        end else begin
                            r_state <= S_SHIFT;
                            r_cnt   <= r_len - CW'(1);
                            r_tms   <= (r_len == CW'(1));
                            r_tdi   <= r_data[0];
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_rise && w_scan) begin
                        r_cap <= r_cap | (r_mask & {MAX_LEN{TDO}});
                    end
                    if (w_fall) begin
                        if (r_cnt != '0) begin
                            // IDLE clocking keeps TMS/TDI low throughout
                            r_cnt  <= r_cnt - CW'(1);
                            r_mask <= r_mask << 1;
                            r_data <= r_data >> 1;
                            r_tdi  <= w_scan && r_data[1];
                            r_tms  <= w_scan && (r_cnt == CW'(1));
                        end else if (!w_scan) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_cap;
                            r_tms       <= 1'b0;
                            r_tdi       <= 1'b0;
                        end else begin
                            r_state <= S_POST;
                            r_pat   <= {4'b0000, C_TRL_PAT};
                            r_cnt   <= CW'(C_TRL_LEN - 1);
                            r_tms   <= C_TRL_PAT[0];
                            r_tdi   <= 1'b0;
                        end
                    end
                end
                S_POST: begin
                    if (w_fall) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CW'(1);
                            r_pat <= {1'b0, r_pat[5:1]};
                            r_tms <= r_pat[1];
                        end else begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_cap;
                            r_tms       <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_host_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_host_shifter
// Description : Self-checking bench for jtag_host_shifter. Stimulus pushes
//               expected responses into a scoreboard; a monitor pops them on
//               RSP_VALID. A TAP state model follows TCK/TMS.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_host_shifter;
    import jtag_host_pkg::*;

    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int PER     = 10;

    // TAP controller states
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PADR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                   SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               CMD_VALID = 1'b0;
    logic               CMD_READY;
    logic [1:0]         CMD_OP = 2'd0;
    logic [LW-1:0]      CMD_LEN = '0;
    logic [MAX_LEN-1:0] CMD_DATA = '0;
    logic               RSP_VALID;
    logic [MAX_LEN-1:0] RSP_DATA;
    logic               BUSY;
    logic               TCK;
    logic               TMS;
    logic               TDI;
    logic               TDO;
    logic               tdo_one = 1'b0;

    assign TDO = tdo_one ? 1'b1 : TDI;

    jtag_host_shifter #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #(PER/2) CLK = ~CLK;

    typedef struct {
        logic [MAX_LEN-1:0] data;
        int                 lat;
        time                t_acc;
    } exp_t;

    exp_t sb[$];
    bit   tms_q[$];
    bit   tdi_q[$];
    int   tap_st    = TLR;
    int   sir_rises = 0;
    int   rsp_cnt   = 0;
    int   errors    = 0;
    int   checks    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int tap_next(input int s, input bit t);
        case (s)
            TLR:     return t ? TLR   : RTI;
            RTI:     return t ? SELDR : RTI;
            SELDR:   return t ? SELIR : CAPDR;
            CAPDR:   return t ? EX1DR : SHDR;
            SHDR:    return t ? EX1DR : SHDR;
            EX1DR:   return t ? UPDR  : PADR;
            PADR:    return t ? EX2DR : PADR;
            EX2DR:   return t ? UPDR  : SHDR;
            UPDR:    return t ? SELDR : RTI;
            SELIR:   return t ? TLR   : CAPIR;
            CAPIR:   return t ? EX1IR : SHIR;
            SHIR:    return t ? EX1IR : SHIR;
            EX1IR:   return t ? UPIR  : PAIR;
            PAIR:    return t ? EX2IR : PAIR;
            EX2IR:   return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    function automatic logic [63:0] bits_from(input bit q[$], input int base);
        logic [63:0] r;
        r = '0;
        for (int i = base; i < q.size() && (i - base) < 64; i++) r[i - base] = q[i];
        return r;
    endfunction

    // Tick logger and TAP model, both clocked by the target-side view of TCK
    always @(posedge TCK) begin
        tms_q.push_back(TMS);
        tdi_q.push_back(TDI);
        if (tap_st == SHIR) sir_rises++;
        tap_st = tap_next(tap_st, TMS);
    end

    // Response monitor
    always @(negedge CLK) begin
        if (RSP_VALID === 1'b1) begin
            exp_t e;
            rsp_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_rsp_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_data", RSP_DATA, e.data);
                check("rsp_latency", 64'(($time - PER/2 - e.t_acc) / PER), 64'(e.lat));
            end
        end
    end

    task automatic send(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data,
                        input logic [MAX_LEN-1:0] exp_d, input int exp_ticks, output time t_acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_LEN   = LW'(len);
        CMD_DATA  = data;
        while (CMD_READY !== 1'b1 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 400) check("accept_timeout", 64'd1, 64'd0);
        @(posedge CLK);
        t_acc   = $time;
        e.data  = exp_d;
        e.lat   = 2 * CLK_DIV * exp_ticks;
        e.t_acc = t_acc;
        sb.push_back(e);
        #1 CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!(CMD_READY === 1'b1 && sb.size() == 0) && n < bound);
        if (n >= bound) check("done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #(PER * 20000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  b;
        int  s;
        int  rc;
        int  n;
        time t1;
        time t2;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("reset_tck", TCK, 0);
        check("reset_tms", TMS, 1);
        check("reset_tdi", TDI, 0);
        check("reset_ready", CMD_READY, 1);
        check("reset_busy", BUSY, 0);
        check("reset_rsp_valid", RSP_VALID, 0);
        check("reset_rsp_data", RSP_DATA, 0);
        @(negedge CLK);
        RST = 1'b0;

        // RESET: 6 ticks 1,1,1,1,1,0, 24-cycle latency
        b = tms_q.size();
        send(OP_RESET, 0, '0, '0, 6, t1);
        wait_done(200);
        check("reset_ticks", 64'(tms_q.size() - b), 6);
        check("reset_tms_seq", bits_from(tms_q, b), 64'h1F);
        check("reset_tdi_seq", bits_from(tdi_q, b), 64'h0);
        check("reset_tap_rti", 64'(tap_st), RTI);

        // SHIFT_DR LEN=8 0xA5 loopback
        b = tms_q.size();
        send(OP_SHIFT_DR, 8, 32'hA5, 32'hA5, 13, t1);
        wait_done(200);
        check("dr8_ticks", 64'(tms_q.size() - b), 13);
        check("dr8_tms_seq", bits_from(tms_q, b), 64'hC01);
        check("dr8_tdi_seq", bits_from(tdi_q, b), 64'h528);
        check("dr8_tap_rti", 64'(tap_st), RTI);

        // SHIFT_IR LEN=4 0x3 with TDO tied high
        tdo_one = 1'b1;
        b = tms_q.size();
        s = sir_rises;
        send(OP_SHIFT_IR, 4, 32'h3, 32'hF, 10, t1);
        wait_done(200);
        check("ir4_ticks", 64'(tms_q.size() - b), 10);
        check("ir4_tms_seq", bits_from(tms_q, b), 64'h183);
        check("ir4_tdi_seq", bits_from(tdi_q, b), 64'h30);
        check("ir4_shift_ir_rises", 64'(sir_rises - s), 4);
        check("ir4_tap_rti", 64'(tap_st), RTI);
        tdo_one = 1'b0;

        // SHIFT_DR LEN=0: no TCK, immediate response
        b = tms_q.size();
        send(OP_SHIFT_DR, 0, 32'hFF, '0, 0, t1);
        wait_done(50);
        check("dr0_ticks", 64'(tms_q.size() - b), 0);

        // SHIFT_DR LEN=40 clamps to 32
        b = tms_q.size();
        send(OP_SHIFT_DR, 40, 32'hDEADBEEF, 32'hDEADBEEF, 37, t1);
        wait_done(400);
        check("dr40_ticks", 64'(tms_q.size() - b), 37);
        check("dr40_tms_seq", bits_from(tms_q, b), 64'h0000_000C_0000_0001);
        check("dr40_tdi_seq", bits_from(tdi_q, b), 64'h6_F56D_F778);

        // IDLE LEN=3, CMD_VALID toggled while busy, then back-to-back DR
        b = tms_q.size();
        send(OP_IDLE, 3, 32'h7, '0, 3, t1);
        repeat (4) begin
            @(negedge CLK);
            CMD_VALID = ~CMD_VALID;
            CMD_OP    = OP_RESET;
        end
        send(OP_SHIFT_DR, 8, 32'h3C, 32'h3C, 13, t2);
        check("b2b_accept_gap", 64'((t2 - t1) / PER), 64'(2 * CLK_DIV * 3 + 1));
        check("idle_ticks", 64'(tms_q.size() - b), 3);
        check("idle_tms_seq", bits_from(tms_q, b), 64'h0);
        check("idle_tdi_seq", bits_from(tdi_q, b), 64'h0);
        b = tms_q.size();
        wait_done(200);
        check("b2b_dr_ticks", 64'(tms_q.size() - b), 13);
        check("b2b_dr_tdi_seq", bits_from(tdi_q, b), 64'h1E0);

        // RST during the 5th shift tick of a DR scan
        b = tms_q.size();
        send(OP_SHIFT_DR, 8, 32'hFF, 32'hFF, 13, t1);
        n = 0;
        while (tms_q.size() - b < 8 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("abort_wait_timeout", 64'd1, 64'd0);
        RST = 1'b1;
        void'(sb.pop_back());
        rc = rsp_cnt;
        @(posedge CLK);
        #1;
        check("abort_tck", TCK, 0);
        check("abort_tms", TMS, 1);
        check("abort_tdi", TDI, 0);
        check("abort_ready", CMD_READY, 1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        check("abort_no_rsp", 64'(rsp_cnt - rc), 0);

        // RESET after abort completes normally
        b = tms_q.size();
        send(OP_RESET, 0, '0, '0, 6, t1);
        wait_done(200);
        check("reset2_ticks", 64'(tms_q.size() - b), 6);
        check("reset2_tms_seq", bits_from(tms_q, b), 64'h1F);
        check("reset2_tap_rti", 64'(tap_st), RTI);
        check("scoreboard_empty", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtag_host_shifter.md
# jtag_host_shifter

JTAG host-side sequencer: the driving end of the TAP protocol that our TAP controller implements on the target side. It accepts one command at a time from a system-side requester: TAP reset, idle clocking, IR scan or DR scan. For each command it generates TCK/TMS/TDI from the system clock and samples TDO into a response word. It sits between a debug/config engine and the board-level JTAG pins, or a simulated TAP target.

## Interface
Parameters:
- MAX_LEN, 32, maximum scan length in bits; width of CMD_DATA/RSP_DATA.
- CLK_DIV, 2, TCK half-period in CLK cycles (≥1).

Ports:
- CLK  in  1  system clock; sole clock.
- RST  in  1  reset; synchronous, active-high.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  block idle, command accepted when CMD_VALID&&CMD_READY.
- CMD_OP  in  2  0=RESET, 1=IDLE, 2=SHIFT_IR, 3=SHIFT_DR.
- CMD_LEN  in  LW=$clog2(MAX_LEN+1)  bit/tick count.
- CMD_DATA  in  MAX_LEN  TDI bits, LSB shifted first.
- RSP_VALID  out  1  one-cycle completion pulse, no backpressure.
- RSP_DATA  out  MAX_LEN  captured TDO bits, right-aligned, held until next RSP_VALID.
- BUSY  out  1  ~CMD_READY.
- TCK  out  1  JTAG clock.
- TMS  out  1  JTAG mode select.
- TDI  out  1  JTAG data to target.
- TDO  in  1  JTAG data from target.

## Operation
- Reset values: TCK=0, TMS=1, TDI=0, CMD_READY=1, BUSY=0, RSP_VALID=0, RSP_DATA=0.
- On accept: latch OP, LEN (values > MAX_LEN are clamped to MAX_LEN), and DATA. Drop CMD_READY.
- All ops other than RESET start and end in Run-Test/Idle. After RESET the target is in Run-Test/Idle.
- TMS sequences, one entry per TCK period:
  - RESET: 1,1,1,1,1,0 (6 ticks; LEN ignored).
  - IDLE: LEN ticks, TMS=0.
  - SHIFT_DR: 1,0,0, then LEN shift ticks (TMS=0, last =1), then 1,0. Total LEN+5.
  - SHIFT_IR: 1,1,0,0, then LEN shift ticks (as DR), then 1,0. Total LEN+6.
- TDI: CMD_DATA[i] during shift tick i; 0 on all other ticks.
- TDO is sampled only on the rising TCK edge of shift ticks. Shift tick i writes RSP_DATA[i]; bits ≥LEN are 0.
- LEN=0 with IDLE/SHIFT_*: no TCK activity. RSP_VALID is pulsed on the cycle after accept with RSP_DATA=0.
- RSP_VALID also fires for RESET/IDLE, with RSP_DATA=0.
- FSM states: S_IDLE → S_PRE (header TMS bits) → S_SHIFT → S_POST (trailer bits) → S_DONE → S_IDLE. RESET uses S_PRE only; IDLE uses S_SHIFT with TMS/TDI forced 0 and no capture.
- S_DONE asserts RSP_VALID and CMD_READY in the same cycle, so a back-to-back accept is legal in that cycle.
- CMD_VALID while busy is ignored; no queueing.
- RST mid-operation: abort. Outputs take reset values on the next cycle, no RSP_VALID, captured bits are discarded.

## Timing
- TCK period = 2·CLK_DIV CLK cycles: low phase CLK_DIV cycles, then high phase CLK_DIV cycles.
- TMS/TDI change only at the start of a low phase, on the same cycle TCK falls or stays low. They are stable for the entire low phase.
- TDO is registered on the CLK edge that drives TCK high.
- With accept at edge k and N ticks, the first low phase starts at edge k. RSP_VALID is high in the cycle starting at edge k + 2·CLK_DIV·N.
- Between commands: TCK=0, and TMS/TDI hold 0 (TMS=1 only out of reset).

## Structure
- Package jtag_host_pkg holds:
  - op code localparams OP_RESET/OP_IDLE/OP_SHIFT_IR/OP_SHIFT_DR;
  - header/trailer TMS patterns and lengths: IR header 4'b0011 LSB-first, len 4; DR header 3'b001, len 3; trailer 2'b01, len 2; reset 6'b011111, len 6;
  - FSM state encoding.
- Sub-module jtag_tck_gen: phase counter over CLK_DIV producing TCK plus one-cycle fall_stb/rise_stb. Enabled by the FSM, and cleared by RST.

## Test plan
- RESET, CLK_DIV=2: 6 TCK pulses with TMS 1,1,1,1,1,0. RSP_VALID exactly 24 cycles after accept, RSP_DATA=0.
- SHIFT_DR, LEN=8, DATA=0xA5, TDO wired to TDI: TMS 1,0,0,0×7,1,1,0 (13 ticks). TDI bits 1,0,1,0,0,1,0,1. RSP_DATA=0x000000A5.
- SHIFT_IR, LEN=4, DATA=0x3, TDO=1, against the team TAP controller model: 10 ticks, TMS 1,1,0,0,0,0,0,1,1,0. The model shows SHIFT_IR high for exactly 4 rising edges. RSP_DATA=0xF; the model ends in Run-Test/Idle.
- SHIFT_DR with LEN=0: no TCK edge, RSP_VALID on the next cycle, RSP_DATA=0. Same op with LEN=40 at MAX_LEN=32: behaves as LEN=32 (37 ticks).
- IDLE LEN=3, then SHIFT_DR presented in the S_DONE cycle: 3 ticks with TMS=TDI=0, then the DR command is accepted with no gap cycle. CMD_VALID toggled during the scan has no effect.
- RST asserted mid-SHIFT_DR, 5th shift tick: next cycle TCK=0, TMS=1, TDI=0, CMD_READY=1, and no RSP_VALID. A subsequent RESET command completes normally.
